// File: rtl/video_pkg.sv
// Shared video definitions: hve bit positions, hve bundle type and scheduler FSM states.
`default_nettype none

package video_pkg;

  localparam int HVE_HSYNC = 2;
  localparam int HVE_VSYNC = 1;
  localparam int HVE_DE    = 0;

  typedef logic [2:0] hve_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SYNC   = 2'd2,
    ST_RUN    = 2'd3
  } sched_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hve_delay_line.sv
// Fixed-depth shift register carrying hve plus the running flag so both stay pixel aligned.
`default_nettype none

module hve_delay_line
  import video_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  hve_t hve_i,
  input  logic run_i,
  output hve_t hve_o,
  output logic run_o
);

  logic [3:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= {hve_i, run_i};
      for (int s = 1; s < DEPTH; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign hve_o = stage_q[DEPTH-1][3:1];
  assign run_o = stage_q[DEPTH-1][0];

endmodule

`default_nettype wire

// File: rtl/frame_scheduler.sv
// Brings up the pixel pipeline after PLL lock, gates DE on frame boundaries and
// schedules the test pattern index, changing it only at vsync rises.
`default_nettype none

module frame_scheduler
  import video_pkg::*;
#(
  parameter int PIPE_LATENCY       = 4,
  parameter int LOCK_SETTLE        = 1024,
  parameter int NUM_PATTERNS       = 4,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int PAT_W              = 2
) (
  input  logic             hdmi_clk,
  input  logic             reset,
  input  logic             i_lock,
  input  logic [2:0]       i_hve,
  input  logic             i_hold,
  input  logic             i_next,
  output logic [2:0]       o_hve,
  output logic [PAT_W-1:0] o_pattern,
  output logic             o_pattern_stb,
  output logic             o_running
);

  localparam int SETTLE_W = cnt_w(LOCK_SETTLE);
  localparam int FRAME_W  = cnt_w(FRAMES_PER_PATTERN);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_SETTLE - 1);
  localparam logic [FRAME_W-1:0]  FRAME_LAST  = FRAME_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [PAT_W-1:0]    PAT_LAST    = PAT_W'(NUM_PATTERNS - 1);

  sched_state_e        state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [PAT_W-1:0]    pattern_q, pattern_d;
  logic                stb_q, stb_d;
  logic                pending_q, pending_d;
  logic                vsync_q;

  logic fb;
  logic frame_wrap;
  logic advance;
  hve_t dly_hve;
  logic dly_run;

  assign fb = i_hve[HVE_VSYNC] & ~vsync_q;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    frame_d    = frame_q;
    pattern_d  = pattern_q;
    stb_d      = 1'b0;
    pending_d  = pending_q | i_next;
    frame_wrap = (frame_q == FRAME_LAST);
    advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        settle_d = '0;
        if (i_lock) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_SYNC;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SYNC: begin
        if (fb) begin
          state_d = ST_RUN;
          frame_d = '0;
        end
      end
      ST_RUN: begin
        if (fb) begin
          frame_d = frame_wrap ? '0 : frame_q + 1'b1;
          // A same-cycle i_next is folded in so it is consumed at this boundary.
          advance = (frame_wrap & ~i_hold) | pending_q | i_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      pattern_d = (pattern_q == PAT_LAST) ? '0 : pattern_q + 1'b1;
      stb_d     = 1'b1;
      pending_d = 1'b0;
    end

    if (!i_lock) begin
      state_d  = ST_IDLE;
      settle_d = '0;
    end
  end

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      frame_q   <= '0;
      pattern_q <= '0;
      stb_q     <= 1'b0;
      pending_q <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      frame_q   <= frame_d;
      pattern_q <= pattern_d;
      stb_q     <= stb_d;
      pending_q <= pending_d;
      vsync_q   <= i_hve[HVE_VSYNC];
    end
  end

  hve_delay_line #(
    .DEPTH (PIPE_LATENCY)
  ) u_delay (
    .clk_i (hdmi_clk),
    .rst_i (reset),
    .hve_i (i_hve),
    .run_i (state_q == ST_RUN),
    .hve_o (dly_hve),
    .run_o (dly_run)
  );

  // Syncs always pass; DE is qualified by the running flag from the same pipe slot.
  always_comb begin
    o_hve            = '0;
    o_hve[HVE_HSYNC] = dly_hve[HVE_HSYNC];
    o_hve[HVE_VSYNC] = dly_hve[HVE_VSYNC];
    o_hve[HVE_DE]    = dly_hve[HVE_DE] & dly_run;
  end

  assign o_pattern     = pattern_q;
  assign o_pattern_stb = stb_q;
  assign o_running     = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: bring-up timing, hve latency/gating, pattern schedule, lock loss, async reset.
`default_nettype none

module tb_frame_scheduler;

  localparam int FL = 32;

  typedef struct {
    logic       hold;
    int         nmid;
    logic       nfb;
    logic [1:0] exp_pat;
    int         exp_stb;
  } vec_t;

  logic       hdmi_clk = 1'b0;
  logic       reset;
  logic       i_lock;
  logic [2:0] i_hve;
  logic       i_hold;
  logic       i_next;
  logic [2:0] o_hve;
  logic [1:0] o_pattern;
  logic       o_pattern_stb;
  logic       o_running;

  frame_scheduler #(
    .PIPE_LATENCY       (4),
    .LOCK_SETTLE        (1024),
    .NUM_PATTERNS       (4),
    .FRAMES_PER_PATTERN (3),
    .PAT_W              (2)
  ) dut (
    .hdmi_clk      (hdmi_clk),
    .reset         (reset),
    .i_lock        (i_lock),
    .i_hve         (i_hve),
    .i_hold        (i_hold),
    .i_next        (i_next),
    .o_hve         (o_hve),
    .o_pattern     (o_pattern),
    .o_pattern_stb (o_pattern_stb),
    .o_running     (o_running)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  int   checks = 0;
  int   errors = 0;
  int   n;
  int   run_at;
  int   stop_at;
  logic exp_run;
  logic [2:0] hist_hve [0:8191];
  logic       hist_run [0:8191];
  vec_t tbl [30];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic hold, input int nmid, input logic nfb,
                              input logic [1:0] pat, input int stb);
    vec_t v;
    v.hold = hold; v.nmid = nmid; v.nfb = nfb; v.exp_pat = pat; v.exp_stb = stb;
    return v;
  endfunction

  // 32-cycle frame: vsync high at c=0..2, hsync every 8 cycles, de in the active area.
  function automatic logic [2:0] gen(input int c);
    logic [2:0] h;
    h[2] = (c % 8) < 2;
    h[1] = c < 3;
    h[0] = (c >= 8) && ((c % 8) >= 3);
    return h;
  endfunction

  task automatic cyc();
    logic [2:0] h;
    logic [2:0] e;
    h = gen(n % FL);
    i_hve = h;
    hist_hve[n+1] = h;
    hist_run[n+1] = exp_run;
    @(posedge hdmi_clk);
    #1;
    n++;
    if (n == run_at)  exp_run = 1'b1;
    if (n == stop_at) exp_run = 1'b0;
    check("running", 32'(o_running), 32'(exp_run));
    if (n >= 4) begin
      e = hist_hve[n-3];
      e[0] = e[0] & hist_run[n-3];
    end else begin
      e = 3'b000;
    end
    check("hve", 32'(o_hve), 32'(e));
  endtask

  task automatic run_frame(input vec_t v);
    int sc;
    sc = 0;
    for (int k = 0; k < FL; k++) begin
      i_hold = v.hold;
      i_next = (k == 0 && v.nfb) || (v.nmid >= 1 && k == 10) ||
               (v.nmid >= 2 && k == 12) || (v.nmid >= 3 && k == 14);
      cyc();
      if (o_pattern_stb) sc++;
      if (k == 0) begin
        check("pat_at_fb", 32'(o_pattern), 32'(v.exp_pat));
        check("stb_at_fb", 32'(o_pattern_stb), 32'(v.exp_stb));
      end
    end
    i_next = 1'b0;
    check("stb_per_frame", 32'(sc), 32'(v.exp_stb));
    check("pat_end", 32'(o_pattern), 32'(v.exp_pat));
  endtask

  // Lock rises together with c=0 of frame 0; RUN entry is the vsync rise at edge 1057.
  task automatic bringup();
    int sc;
    sc = 0;
    n = 0; exp_run = 1'b0; run_at = 1057; stop_at = -1;
    i_lock = 1'b1; i_hold = 1'b0; i_next = 1'b0;
    for (int k = 0; k < 34 * FL; k++) begin
      cyc();
      if (o_pattern_stb) sc++;
    end
    check("bringup_stb", 32'(sc), 32'd0);
    check("bringup_pat", 32'(o_pattern), 32'd0);
  endtask

  initial begin
    int d;

    tbl[0]  = mk(0, 0, 0, 2'd0, 0);
    tbl[1]  = mk(0, 0, 0, 2'd0, 0);
    tbl[2]  = mk(0, 0, 0, 2'd1, 1);
    tbl[3]  = mk(0, 0, 0, 2'd1, 0);
    tbl[4]  = mk(0, 0, 0, 2'd1, 0);
    tbl[5]  = mk(0, 0, 0, 2'd2, 1);
    tbl[6]  = mk(0, 0, 0, 2'd2, 0);
    tbl[7]  = mk(0, 0, 0, 2'd2, 0);
    tbl[8]  = mk(0, 0, 0, 2'd3, 1);
    tbl[9]  = mk(0, 0, 0, 2'd3, 0);
    tbl[10] = mk(0, 0, 0, 2'd3, 0);
    tbl[11] = mk(0, 0, 0, 2'd0, 1);
    tbl[12] = mk(0, 0, 0, 2'd0, 0);
    for (int i = 13; i < 22; i++) tbl[i] = mk(1, 0, 0, 2'd0, 0);
    tbl[22] = mk(1, 1, 0, 2'd0, 0);
    tbl[23] = mk(1, 0, 0, 2'd1, 1);
    tbl[24] = mk(0, 3, 0, 2'd1, 0);
    tbl[25] = mk(0, 0, 1, 2'd2, 1);
    tbl[26] = mk(1, 0, 0, 2'd2, 0);
    tbl[27] = mk(0, 0, 0, 2'd2, 0);
    tbl[28] = mk(0, 0, 1, 2'd3, 1);
    tbl[29] = mk(1, 0, 0, 2'd3, 0);

    reset = 1'b1; i_lock = 1'b0; i_hold = 1'b0; i_next = 1'b0; i_hve = 3'b000;
    n = 0; exp_run = 1'b0; run_at = -1; stop_at = -1;
    repeat (3) @(posedge hdmi_clk);
    #1;
    check("rst_hve", 32'(o_hve), 32'd0);
    check("rst_pat", 32'(o_pattern), 32'd0);
    check("rst_stb", 32'(o_pattern_stb), 32'd0);
    check("rst_running", 32'(o_running), 32'd0);
    reset = 1'b0;

    bringup();
    for (int i = 0; i < 30; i++) run_frame(tbl[i]);
    i_hold = 1'b0;

    // One-cycle lock drop in RUN, then a one-cycle glitch 500 edges into the settle.
    repeat (5) cyc();
    d = n + 1;
    stop_at = d;
    run_at = d + 1531;
    i_lock = 1'b0;
    cyc();
    i_lock = 1'b1;
    while (n < d + 499) cyc();
    i_lock = 1'b0;
    cyc();
    i_lock = 1'b1;
    while (n < d + 1571) cyc();
    check("pat_kept", 32'(o_pattern), 32'd3);

    // Asynchronous reset in the middle of an active line.
    while (n % FL != 15) cyc();
    check("pre_reset_hve", 32'(o_hve), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_hve", 32'(o_hve), 32'd0);
    check("arst_pat", 32'(o_pattern), 32'd0);
    check("arst_stb", 32'(o_pattern_stb), 32'd0);
    check("arst_running", 32'(o_running), 32'd0);
    i_lock = 1'b0; i_hve = 3'b000;
    repeat (2) @(posedge hdmi_clk);
    #1;
    reset = 1'b0;

    // i_next while IDLE stays pending until the first RUN boundary after entry.
    for (int k = 0; k < 5; k++) begin
      i_next = (k == 1);
      @(posedge hdmi_clk);
      #1;
    end
    i_next = 1'b0;
    check("idle_next_pat", 32'(o_pattern), 32'd0);
    bringup();
    run_frame(mk(0, 0, 0, 2'd1, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Sequences the pixel pipeline between display_signal and the hdmi encoder, running in the hdmi_clk domain.
- Gates data-enable until the pixel clock is locked and settled, and starts output on a clean frame boundary.
- Delays hve to match the colour datapath latency.
- Schedules which test pattern the colour generator produces, changing it only at frame boundaries.

Parameters:
- PIPE_LATENCY, 4: hve delay in cycles; must equal the colour-path latency; legal range 1..16.
- LOCK_SETTLE, 1024: consecutive cycles i_lock must be high before output is enabled.
- NUM_PATTERNS, 4: number of patterns; o_pattern wraps modulo this value.
- FRAMES_PER_PATTERN, 120: frames per pattern during auto-rotation; must be ≥1.
- PAT_W, 2: width of o_pattern; must be ≥ clog2(NUM_PATTERNS).

Ports:
- hdmi_clk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- i_lock  in  1  PLL lock, already synchronous to hdmi_clk.
- i_hve  in  3  {hsync, vsync, de} from display_signal.
- i_hold  in  1  level; while high, auto-rotation is frozen.
- i_next  in  1  one-cycle pulse; requests a pattern advance at the next frame boundary.
- o_hve  out  3  i_hve delayed by PIPE_LATENCY; de is gated.
- o_pattern  out  PAT_W  current pattern index.
- o_pattern_stb  out  1  one-cycle pulse in the cycle o_pattern changes.
- o_running  out  1  high while the FSM is in RUN.

Behaviour:
- Reset values:
  - o_hve=0, o_pattern=0, o_pattern_stb=0, o_running=0.
  - FSM=IDLE; settle, frame and pending registers cleared.
  - Delay line cleared to 0.
- Frame boundary (fb): rising edge of i_hve[1] (vsync). Detect it with a registered previous vsync; fb is asserted in the cycle vsync is first seen high.
- FSM:
  - IDLE: settle counter held at 0. Go to SETTLE when i_lock=1.
  - SETTLE: counter increments each cycle i_lock=1. Go to SYNC when the counter reaches LOCK_SETTLE-1.
  - SYNC: wait for fb, then go to RUN. The frame counter is cleared on entry to RUN.
  - RUN: o_running=1.
  - From any state, i_lock=0 sampled → IDLE on the next edge. This takes priority over all other transitions. A lock glitch in SETTLE restarts the count from 0.
- hve path:
  - PIPE_LATENCY-stage shift register on i_hve.
  - Sync bits always pass through, so the sink keeps timing during bring-up.
  - o_hve[0] = delayed de AND the running flag, where the running flag is delayed by the same PIPE_LATENCY.
  - Result: enable and disable take effect at a pixel-aligned point, never mid-pipe.
- Pattern scheduler (RUN only; counters frozen in all other states):
  - At fb: if the frame counter = FRAMES_PER_PATTERN-1, clear it; otherwise increment it.
  - Advance condition at fb: (frame counter wrap AND i_hold=0) OR pending.
  - On advance: o_pattern ← (o_pattern+1) mod NUM_PATTERNS, o_pattern_stb=1 for that cycle, pending cleared.
  - i_next sets pending in any state; the advance is applied only at a RUN fb.
  - i_next in the same cycle as fb: advances at that fb; pending is not left set afterwards.
  - Multiple i_next pulses within one frame produce a single advance.
  - i_hold does not block pending advances.
- Leaving RUN (lock loss):
  - o_pattern keeps its value; pending is kept.
  - The frame counter is cleared on re-entry to RUN.
- Asynchronous reset mid-frame: all outputs go to reset values immediately; o_hve=0 until reset releases and data shifts through.

Decomposition:
- Shared package video_pkg: hve bit indices (HVE_HSYNC=2, HVE_VSYNC=1, HVE_DE=0), typedef for the FSM state enum, typedef hve_t (3-bit).
- One sub-module: hve_delay_line (parameterised depth, async reset, 3+1 bits wide: hve plus the running flag).

Test Plan:
- Reset then i_lock=1 held: o_running rises at the first vsync rise after 1024+ lock cycles. Before that, o_hve[0]=0 while sync bits toggle; after, o_hve tracks i_hve with exactly 4-cycle latency.
- Lock drop for 1 cycle in RUN: o_running=0 next cycle; de is masked after 4 cycles; relock requires a full 1024 settle plus fb. Lock glitch in SETTLE: the count restarts.
- FRAMES_PER_PATTERN=3, NUM_PATTERNS=4, 13 frames in RUN: o_pattern steps 0→1→2→3→0 at frames 3, 6, 9, 12; each step has a single o_pattern_stb pulse, aligned to a vsync rise.
- i_hold=1 for 10 frames: no change. i_next pulsed mid-frame while held: o_pattern increments exactly once, at the next vsync rise.
- i_next pulsed 3 times in one frame plus once coincident with fb: one advance per boundary; pending is 0 afterwards.
- i_next pulsed in IDLE: no change until RUN, then one advance at the first RUN fb after the entry boundary. Asynchronous reset asserted mid-line: all outputs are 0 in the same cycle.
